// File: rtl/mult_booth_pkg.sv
// ============================================================================
// Module      : mult_booth_pkg
// Description : Shared constants and FSM state encoding for the Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_booth_pkg;

  localparam int MULT_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

endpackage

`default_nettype wire

// File: rtl/mult_booth_if.sv
// ============================================================================
// Module      : mult_booth_if
// Description : Start/busy/done handshake and operand/result bus of the multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mult_booth_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, A, B, input busy, done, hi, lo);
  modport slave  (input start, A, B, output busy, done, hi, lo);

endinterface

`default_nettype wire

// File: rtl/mult_booth_booth_step.sv
// ============================================================================
// Module      : booth_step
// Description : One radix-2 Booth step: conditional add/sub then arithmetic shift.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module booth_step #(
  parameter int WIDTH = 32
) (
  input  wire logic [WIDTH:0] acc_i,
  input  wire logic [WIDTH:0] m_i,
  input  wire logic           q0_i,
  input  wire logic           qm1_i,
  output logic      [WIDTH:0] acc_o,
  output logic                q_msb_o,
  output logic                qm1_o
);

  logic [WIDTH:0] w_sum;

  always_comb begin
    unique case ({q0_i, qm1_i})
      2'b01:   w_sum = acc_i + m_i;
      2'b10:   w_sum = acc_i - m_i;
      default: w_sum = acc_i;
    endcase
    // The acc LSB shifts into the top of q; the acc MSB is replicated.
    acc_o   = {w_sum[WIDTH], w_sum[WIDTH:1]};
    q_msb_o = w_sum[0];
    qm1_o   = q0_i;
  end

endmodule

`default_nettype wire

// File: rtl/mult_booth.sv
// ============================================================================
// Module      : mult_booth
// Description : Sequential signed WIDTHxWIDTH radix-2 Booth multiplier, one step per clock.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_booth
  import mult_booth_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input wire logic    clk,
  input wire logic    reset,
  mult_booth_if.slave bus
);

  mult_state_e      state_q, state_d;
  logic [WIDTH:0]   acc_q, acc_d;
  logic [WIDTH:0]   m_q, m_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             qm1_q, qm1_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [WIDTH:0]   w_acc_step;
  logic             w_q_msb;
  logic             w_qm1_step;

  booth_step #(.WIDTH(WIDTH)) u_booth_step (
    .acc_i   (acc_q),
    .m_i     (m_q),
    .q0_i    (q_q[0]),
    .qm1_i   (qm1_q),
    .acc_o   (w_acc_step),
    .q_msb_o (w_q_msb),
    .qm1_o   (w_qm1_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      m_q     <= '0;
      q_q     <= '0;
      qm1_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      m_q     <= m_d;
      q_q     <= q_d;
      qm1_q   <= qm1_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (count_q == CNT_W'(1)) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers only move on acceptance and during RUN; hi/lo hold otherwise.
  always_comb begin
    acc_d   = acc_q;
    m_d     = m_q;
    q_d     = q_q;
    qm1_d   = qm1_q;
    count_d = count_q;
    if (state_q == IDLE && bus.start) begin
      acc_d   = '0;
      m_d     = {bus.A[WIDTH-1], bus.A};
      q_d     = bus.B;
      qm1_d   = 1'b0;
      count_d = CNT_W'(WIDTH);
    end else if (state_q == RUN) begin
      acc_d   = w_acc_step;
      q_d     = {w_q_msb, q_q[WIDTH-1:1]};
      qm1_d   = w_qm1_step;
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    bus.busy = (state_q != IDLE);
    bus.done = (state_q == DONE);
    bus.hi   = acc_q[WIDTH-1:0];
    bus.lo   = q_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_mult_booth.sv
// ============================================================================
// Module      : tb_mult_booth
// Description : Directed vector bench for mult_booth, plus abort/ignore/back-to-back sequences.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mult_booth;

  logic clk;
  logic reset;

  mult_booth_if #(.WIDTH(32)) bus ();

  mult_booth #(.WIDTH(32), .CNT_W(6)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic accept(input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.A     = $urandom;
    bus.B     = $urandom;
    check("busy_after_accept", {63'd0, bus.busy}, 64'd1);
  endtask

  // Edges counted from the acceptance edge until done is first seen.
  task automatic wait_done(input int already, output int edges);
    edges = already;
    while (!bus.done && edges < 40) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic finish_op(input string name, input logic [31:0] hi, input logic [31:0] lo);
    check({name, "_hi"}, {32'd0, bus.hi}, {32'd0, hi});
    check({name, "_lo"}, {32'd0, bus.lo}, {32'd0, lo});
    @(posedge clk); #1;
    check({name, "_done_one_cycle"}, {63'd0, bus.done}, 64'd0);
    check({name, "_idle_after"}, {63'd0, bus.busy}, 64'd0);
  endtask

  initial begin
    int edges;
    int done_seen;

    vecs[0] = '{32'd3,         32'd5,         32'h00000000, 32'h0000000F};
    vecs[1] = '{32'hFFFFFFF9,  32'd6,         32'hFFFFFFFF, 32'hFFFFFFD6};
    vecs[2] = '{32'h80000000,  32'h80000000,  32'h40000000, 32'h00000000};
    vecs[3] = '{32'h7FFFFFFF,  32'h80000000,  32'hC0000000, 32'h80000000};
    vecs[4] = '{32'hFFFFFFFF,  32'hFFFFFFFF,  32'h00000000, 32'h00000001};
    vecs[5] = '{32'd0,         32'h12345678,  32'h00000000, 32'h00000000};
    vecs[6] = '{32'd1,         32'hDEADBEEF,  32'hFFFFFFFF, 32'hDEADBEEF};
    vecs[7] = '{32'h80000000,  32'hFFFFFFFF,  32'h00000000, 32'h80000000};
    vecs[8] = '{32'h7FFFFFFF,  32'h7FFFFFFF,  32'h3FFFFFFF, 32'h00000001};
    vecs[9] = '{32'd12345,     32'd678,       32'h00000000, 32'h007FB6F6};

    reset     = 1'b0;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    #12;
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_done", {63'd0, bus.done}, 64'd0);
    check("reset_hi",   {32'd0, bus.hi},   64'd0);
    check("reset_lo",   {32'd0, bus.lo},   64'd0);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;

    // done is high in the 33rd cycle after acceptance: 32 edges past it.
    for (int i = 0; i < 10; i++) begin
      accept(vecs[i].a, vecs[i].b);
      wait_done(0, edges);
      check($sformatf("vec%0d_latency", i), 64'(edges), 64'd32);
      finish_op($sformatf("vec%0d", i), vecs[i].hi, vecs[i].lo);
    end

    // Start pulse while busy must be ignored.
    accept(32'd12345, 32'd678);
    repeat (9) begin @(posedge clk); #1; end
    bus.start = 1'b1;
    bus.A     = 32'd5;
    bus.B     = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("ignored_start_no_done", {63'd0, bus.done}, 64'd0);
    wait_done(10, edges);
    check("ignored_start_latency", 64'(edges), 64'd32);
    finish_op("ignored_start", 32'h00000000, 32'h007FB6F6);

    // Asynchronous reset mid-operation aborts with no done.
    accept(32'h00001234, 32'h00005678);
    repeat (15) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check("abort_busy", {63'd0, bus.busy}, 64'd0);
    check("abort_done", {63'd0, bus.done}, 64'd0);
    check("abort_hi",   {32'd0, bus.hi},   64'd0);
    check("abort_lo",   {32'd0, bus.lo},   64'd0);
    @(negedge clk) reset = 1'b1;
    done_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) done_seen++;
    end
    check("abort_no_done", 64'(done_seen), 64'd0);
    accept(32'd2, 32'd2);
    wait_done(0, edges);
    check("after_abort_latency", 64'(edges), 64'd32);
    finish_op("after_abort", 32'h00000000, 32'h00000004);

    // Back-to-back: results hold in IDLE until the next acceptance edge.
    accept(32'd3, 32'd5);
    wait_done(0, edges);
    check("b2b_first_latency", 64'(edges), 64'd32);
    finish_op("b2b_first", 32'h00000000, 32'h0000000F);
    check("b2b_hold_hi", {32'd0, bus.hi}, 64'h0);
    check("b2b_hold_lo", {32'd0, bus.lo}, 64'hF);
    accept(32'hFFFFFFF9, 32'd6);
    wait_done(0, edges);
    check("b2b_second_latency", 64'(edges), 64'd32);
    finish_op("b2b_second", 32'hFFFFFFFF, 32'hFFFFFFD6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
